prpg_lfsr_gen: RTL and testbench
================================

// Module: prpg_lfsr_gen
// PURPOSE
//  Parametrised Galois-LFSR pseudo-random pattern generator. Successor to the fixed-width
//  Random generator: adds configurable width/polynomial, runtime seed load, a valid/ready
//  output stream, period-wrap flag and optional MISR signature mode. Feeds BIST/test-pattern
//  consumers that may stall.
// PARAMETERS
//  WIDTH    4..64, default 16        state / pattern width
//  TAPS     WIDTH bits, default 'hB400 Galois feedback mask (bit i set = XOR into bit i)
//  SEED     WIDTH bits, default 1     seed value loaded by set_syn
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  set_syn    in   1      synchronous, active-high reset
//  en         in   1      run request
//  load       in   1      load seed_in into state (one-cycle pulse)
//  seed_in    in   WIDTH  runtime seed
//  out_data   out  WIDTH  current pattern (= state)
//  out_valid  out  1      out_data valid
//  out_ready  in   1      consumer accepts out_data
//  wrap       out  1      one-cycle pulse: state returned to active seed
// BEHAVIOUR
//  - Reset (set_syn=1 at edge): state=SEED (SEED==0 -> 1), seed_reg=same, FSM=IDLE,
//    out_valid=0, wrap=0. Overrides every other input.
//  - Step fn g(s) = s[0] ? (s>>1)^TAPS : (s>>1). Advance: state<=g(state) on any edge where
//    out_valid && out_ready. No other state change except reset/load.
//  - FSM: IDLE: out_valid=0; en=1 -> RUN (out_valid=1 the next cycle, data=state, no step).
//    RUN: out_valid=1; en=0 and transfer this edge -> IDLE; en=0 without transfer -> DRAIN.
//    DRAIN: out_valid=1, data held; transfer -> IDLE. en ignored in DRAIN.
//  - Stall: out_valid=1 && out_ready=0 -> out_data stable, never drops (except load/reset).
//  - load=1 (any state): state<=seed_in, seed_reg<=seed_in; seed_in==0 -> 1 (no lock-up).
//    Beats a same-cycle advance; pending beat discarded; FSM -> IDLE, out_valid=0 next
//    cycle; resumes if en=1. load && set_syn -> reset wins.
//  - wrap=1 for the one cycle after an advance whose g(state)==seed_reg; otherwise 0.
//    Maximal TAPS: one wrap per 2^WIDTH-1 accepted beats. Load clears wrap.
//  - Throughput 1 pattern/cycle with out_ready tied high; zero-state never reachable.
// CONFIGURATION
//  PRPG_MISR_EN defined: adds ports misr_mode (in,1) and misr_din (in,WIDTH). misr_mode=1:
//    advance computes g(state)^misr_din (signature compaction); result may be 0 (legal);
//    wrap still compares to seed_reg. misr_mode=0: identical to plain generator.
//  PRPG_MISR_EN undefined: ports absent; pure generator, no MISR logic.
// TESTING (WIDTH=4, TAPS=4'hC, SEED=4'h1)
//  1 Reset, en=1, out_ready=1 -> out_data 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1; wrap pulses
//    once, cycle after the beat with 2 is accepted; 15-beat period repeats.
//  2 Stream at 3, out_ready=0 for 5 cycles -> out_data=3, out_valid=1 throughout; ready=1
//    -> next beat D.
//  3 en=0 while stalled on 6 -> DRAIN, 6 held; ready=1 -> accepted, out_valid=0, state=3.
//  4 load=1, seed_in=4'h0 mid-stream -> next cycle out_valid=0, state=1; en=1 -> resumes
//    at 1; load seed_in=9 -> sequence 9,8,4,2,1,C...; wrap after 9 re-reached.
//  5 set_syn=1 together with load=1, seed_in=7 -> state=1, out_valid=0, wrap=0.
//  6 PRPG_MISR_EN, misr_mode=1, state=1, misr_din=4'hC -> next state 0 (C^C), no lock-up
//    fix; misr_din=0 -> next state g(0)=0. Build without macro: test 1 unchanged.

Source files
------------

// File: rtl/prpg_lfsr_gen.sv
// Galois-LFSR pattern generator with seed load, a valid/ready output stream and a period-wrap flag.
// Define PRPG_MISR_EN to add misr_mode/misr_din ports for signature compaction.
module prpg_lfsr_gen #(
  parameter int                WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             set_syn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap
`ifdef PRPG_MISR_EN
  ,
  input  logic             misr_mode,
  input  logic [WIDTH-1:0] misr_din
`endif
);

  // A zero seed would lock the LFSR, so it is replaced by 1 on every seed path.
  localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? WIDTH'(1) : SEED;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] seed_fix;
  logic [WIDTH-1:0] adv;
  logic             xfer;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Handshake: a beat transfers on any rising edge where out_valid && out_ready;
  // once raised, out_valid holds with out_data stable until that transfer (load/reset excepted).
  always_comb begin
    xfer     = out_valid & out_ready;
    seed_fix = (seed_in == '0) ? WIDTH'(1) : seed_in;
`ifdef PRPG_MISR_EN
    adv = misr_mode ? (step(state) ^ misr_din) : step(state);
`else
    adv = step(state);
`endif
  end

  always_ff @(posedge clk) begin
    if (set_syn) begin
      state     <= SEED_INIT;
      seed_reg  <= SEED_INIT;
      fsm       <= IDLE;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      state     <= seed_fix;
      seed_reg  <= seed_fix;
      fsm       <= IDLE;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      if (xfer) begin
        state <= adv;
        wrap  <= (adv == seed_reg);
      end else begin
        wrap  <= 1'b0;
      end
      case (fsm)
        IDLE: begin
          if (en) begin
            fsm       <= RUN;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            if (xfer) begin
              fsm       <= IDLE;
              out_valid <= 1'b0;
            end else begin
              fsm       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = state;

endmodule

// File: tb/tb_prpg_lfsr_gen.sv
// Directed bench for prpg_lfsr_gen at WIDTH=4, TAPS=4'hC, SEED=4'h1.
// Expected patterns are hand-derived from g(s) = s[0] ? (s>>1)^C : s>>1.
module tb_prpg_lfsr_gen;

  logic       clk;
  logic       set_syn;
  logic       en;
  logic       load;
  logic [3:0] seed_in;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       wrap;
`ifdef PRPG_MISR_EN
  logic       misr_mode;
  logic [3:0] misr_din;
`endif

  int compared;
  int mismatched;

  logic [3:0] seq1[15];
  logic [3:0] seq9[15];

  prpg_lfsr_gen #(
    .WIDTH(4),
    .TAPS (4'hC),
    .SEED (4'h1)
  ) dut (
    .clk      (clk),
    .set_syn  (set_syn),
    .en       (en),
    .load     (load),
    .seed_in  (seed_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wrap     (wrap)
`ifdef PRPG_MISR_EN
    ,
    .misr_mode(misr_mode),
    .misr_din (misr_din)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [3:0] data, input logic valid,
                            input logic wr);
    check({tag, "_data"}, out_data, data);
    check({tag, "_valid"}, {3'b0, out_valid}, {3'b0, valid});
    check({tag, "_wrap"}, {3'b0, wrap}, {3'b0, wr});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    seq1 = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
             4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
    seq9 = '{4'h9, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h6, 4'h3,
             4'hD, 4'hA, 4'h5, 4'hE, 4'h7, 4'hF, 4'hB};
    set_syn   = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    seed_in   = 4'h0;
    out_ready = 1'b0;
`ifdef PRPG_MISR_EN
    misr_mode = 1'b0;
    misr_din  = 4'h0;
`endif
    tick();
    tick();
    check_beat("reset", 4'h1, 1'b0, 1'b0);

    // Full period twice with ready tied high; wrap follows the accepted 2.
    set_syn   = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 30; k++) begin
      check_beat($sformatf("period_k%0d", k), seq1[k % 15], 1'b1, (k % 15 == 0) && (k > 0));
      tick();
    end
    check_beat("period_end", 4'h1, 1'b1, 1'b1);

    // Stall on 3 for five cycles, then release.
    repeat (3) tick();
    check("at3_data", out_data, 4'h3);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_beat($sformatf("stall_k%0d", k), 4'h3, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check_beat("stall_release", 4'hD, 1'b1, 1'b0);

    // Walk to 6, stall, drop en -> DRAIN holds 6 and ignores en.
    repeat (13) tick();
    check("at6_data", out_data, 4'h6);
    out_ready = 1'b0;
    tick();
    en = 1'b0;
    tick();
    check_beat("drain_hold", 4'h6, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    check_beat("drain_en_ignored", 4'h6, 1'b1, 1'b0);
    en        = 1'b0;
    out_ready = 1'b1;
    tick();
    check_beat("drain_accept", 4'h3, 1'b0, 1'b0);
    tick();
    check_beat("idle_hold", 4'h3, 1'b0, 1'b0);

    // Load of zero seed mid-stream falls back to 1 and resumes.
    en = 1'b1;
    tick();
    check_beat("rerun", 4'h3, 1'b1, 1'b0);
    tick();
    check("rerun_step", out_data, 4'hD);
    load    = 1'b1;
    seed_in = 4'h0;
    tick();
    load = 1'b0;
    check_beat("load0", 4'h1, 1'b0, 1'b0);
    tick();
    check_beat("load0_resume", 4'h1, 1'b1, 1'b0);
    tick();
    check("load0_step", out_data, 4'hC);

    // Load 9 beats the same-cycle transfer; wrap fires when 9 returns.
    load    = 1'b1;
    seed_in = 4'h9;
    tick();
    load = 1'b0;
    check_beat("load9", 4'h9, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      check_beat($sformatf("seed9_k%0d", k), seq9[k % 15], 1'b1, k == 15);
      tick();
    end

    // Reset wins over a simultaneous load.
    set_syn = 1'b1;
    load    = 1'b1;
    seed_in = 4'h7;
    tick();
    set_syn = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    check_beat("reset_vs_load", 4'h1, 1'b0, 1'b0);
    tick();
    check_beat("reset_idle", 4'h1, 1'b0, 1'b0);

    // RUN with en dropped on a transfer edge goes straight to IDLE.
    en = 1'b1;
    tick();
    check_beat("run_again", 4'h1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    check_beat("run_to_idle", 4'hC, 1'b0, 1'b0);

`ifdef PRPG_MISR_EN
    set_syn = 1'b1;
    tick();
    set_syn = 1'b0;
    en      = 1'b1;
    tick();
    check_beat("misr_start", 4'h1, 1'b1, 1'b0);
    misr_mode = 1'b1;
    misr_din  = 4'hC;
    tick();
    check_beat("misr_zero", 4'h0, 1'b1, 1'b0);
    misr_din = 4'h0;
    tick();
    check_beat("misr_hold_zero", 4'h0, 1'b1, 1'b0);
    misr_mode = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
